booth_mul_seq: RTL and testbench

BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

---
 rtl/mul_pkg.sv | 28 ++
 rtl/booth_mul_ctrl.sv | 59 +++++
 rtl/booth_mul_seq.sv | 85 ++++++++
 tb/tb_booth_mul_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// FSM state codes and Booth-step encoding.
package mul_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    typedef logic [1:0] booth_op_t;

    localparam booth_op_t BOOTH_NOP = 2'b00;
    localparam booth_op_t BOOTH_ADD = 2'b01;
    localparam booth_op_t BOOTH_SUB = 2'b10;

    // Radix-2 Booth recoding of the pair {Q[0], Qm1}.
    function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
        booth_op_t op;
        case ({q0, qm1})
            2'b10:   op = BOOTH_SUB;
            2'b01:   op = BOOTH_ADD;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_mul_ctrl.sv
// Control FSM and step counter for booth_mul_seq: sequences load, WIDTH+1
// Booth steps and a single DONE cycle.
module booth_mul_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic q0,
    input  logic qm1,
    output logic load,
    output logic step,
    output logic op_add,
    output logic op_sub,
    output logic finish,
    output logic busy
);

    state_t          state;
    logic   [CW-1:0] count;
    booth_op_t       booth_op;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        count <= '0;
                    end
                end
                RUN: begin
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign booth_op = booth_decode(q0, qm1);

    assign load   = (state == IDLE) && start;
    assign step   = (state == RUN);
    assign op_add = step && (booth_op == BOOTH_ADD);
    assign op_sub = step && (booth_op == BOOTH_SUB);
    assign finish = (state == DONE);
    assign busy   = step || finish;

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned, one Booth step per
// cycle on a WIDTH+1 bit datapath; done pulses WIDTH+2 cycles after start.
module booth_mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic [WIDTH:0] a;
    logic [WIDTH:0] q;
    logic [WIDTH:0] m;
    logic           qm1;

    logic [WIDTH:0] ext_mcand;
    logic [WIDTH:0] ext_mplier;
    logic [WIDTH:0] a_sum;

    logic load;
    logic step;
    logic op_add;
    logic op_sub;
    logic finish;

    booth_mul_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .q0     (q[0]),
        .qm1    (qm1),
        .load   (load),
        .step   (step),
        .op_add (op_add),
        .op_sub (op_sub),
        .finish (finish),
        .busy   (busy)
    );

    // The extra top bit lets the most negative operand survive negation.
    assign ext_mcand  = {signed_mode & multiplicand[WIDTH-1], multiplicand};
    assign ext_mplier = {signed_mode & multiplier[WIDTH-1], multiplier};

    always_comb begin
        a_sum = a;
        if (op_add)      a_sum = a + m;
        else if (op_sub) a_sum = a - m;
    end

    // NOTE: the datapath registers share the asynchronous reset so an aborted
    // operation leaves no stale operands or partial products behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a       <= '0;
            q       <= '0;
            qm1     <= 1'b0;
            m       <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            if (load) begin
                a   <= '0;
                q   <= ext_mplier;
                qm1 <= 1'b0;
                m   <= ext_mcand;
            end else if (step) begin
                // Arithmetic right shift of {A,Q,Qm1} using the updated A.
                a   <= {a_sum[WIDTH], a_sum[WIDTH:1]};
                q   <= {a_sum[0], q[WIDTH:1]};
                qm1 <= q[0];
            end
            done <= finish;
            if (finish) product <= {a[WIDTH-2:0], q};
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed WIDTH=8 cases plus a
// randomized WIDTH=16 sweep against an arithmetic reference model.
module tb_booth_mul_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  mc8, mq8;
    logic [15:0] product8;

    logic        start16, sm16, busy16, done16;
    logic [15:0] mc16, mq16;
    logic [31:0] product16;

    int passed = 0;
    int total  = 0;

    booth_mul_seq #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .rst          (rst),
        .start        (start8),
        .signed_mode  (sm8),
        .multiplicand (mc8),
        .multiplier   (mq8),
        .busy         (busy8),
        .done         (done8),
        .product      (product8)
    );

    booth_mul_seq #(.WIDTH(16)) dut16 (
        .clk          (clk),
        .rst          (rst),
        .start        (start16),
        .signed_mode  (sm16),
        .multiplicand (mc16),
        .multiplier   (mq16),
        .busy         (busy16),
        .done         (done16),
        .product      (product16)
    );

    // Reference: interpret operands per mode, multiply, keep low 2*w bits.
    function automatic longint ref_mul(input logic s, input int w,
                                       input longint m, input longint q);
        longint a, b;
        a = m;
        b = q;
        if (s && m[w-1]) a = m - (longint'(1) << w);
        if (s && q[w-1]) b = q - (longint'(1) << w);
        return (a * b) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    task automatic run8(input logic s, input logic [7:0] m, input logic [7:0] q,
                        output logic [15:0] prod, output int lat,
                        output int width, output logic bsy);
        @(negedge clk);
        start8 = 1'b1; sm8 = s; mc8 = m; mq8 = q;
        @(posedge clk); #1;
        start8 = 1'b0; sm8 = 1'($urandom); mc8 = 8'($urandom); mq8 = 8'($urandom);
        bsy = busy8;
        lat = -1; width = 0; prod = '0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (done8) begin lat = k; prod = product8; end
        end
        if (lat >= 0) begin
            width = 1;
            for (int j = 0; j < 10; j++) begin
                @(posedge clk); #1;
                if (done8) width++;
                else break;
            end
        end
    endtask

    task automatic run16(input logic s, input logic [15:0] m, input logic [15:0] q,
                         output logic [31:0] prod, output int lat, output int width);
        @(negedge clk);
        start16 = 1'b1; sm16 = s; mc16 = m; mq16 = q;
        @(posedge clk); #1;
        start16 = 1'b0; sm16 = 1'($urandom); mc16 = 16'($urandom); mq16 = 16'($urandom);
        lat = -1; width = 0; prod = '0;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (done16) begin lat = k; prod = product16; end
        end
        if (lat >= 0) begin
            width = 1;
            for (int j = 0; j < 10; j++) begin
                @(posedge clk); #1;
                if (done16) width++;
                else break;
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        rst = 1'b1;
        start8 = 1'b0; sm8 = 1'b0; mc8 = '0; mq8 = '0;
        start16 = 1'b0; sm16 = 1'b0; mc16 = '0; mq16 = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy8, done8, product8} !== 18'd0) $display("FAIL reset8 got busy=%b done=%b product=%h want 0/0/0000", busy8, done8, product8);
        else passed++;
        total++;
        if ({busy16, done16, product16} !== 34'd0) $display("FAIL reset16 got busy=%b done=%b product=%h want 0/0/0", busy16, done16, product16);
        else passed++;
        // Start presented on the very first edge after reset release.
        @(negedge clk);
        rst = 1'b0;
        start8 = 1'b1; sm8 = 1'b1; mc8 = 8'h80; mq8 = 8'h7F;
        @(posedge clk); #1;
        start8 = 1'b0;
        total++;
        if (busy8 !== 1'b1) $display("FAIL first_edge_accept got busy=%b want 1", busy8);
        else passed++;
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (done8) lat = k;
        end
        total++;
        if (lat != 10 || product8 !== 16'hC080) $display("FAIL first_edge_result got lat=%0d product=%h want 10/c080", lat, product8);
        else passed++;
        @(posedge clk); #1;
    endtask

    typedef struct { logic s; logic [7:0] m; logic [7:0] q; logic [15:0] exp; } vec8_t;

    task automatic test_directed();
        vec8_t vecs[5];
        logic [15:0] prod;
        int lat, width;
        logic bsy;
        vecs[0] = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
        vecs[1] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[2] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vecs[3] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[4] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        foreach (vecs[i]) begin
            run8(vecs[i].s, vecs[i].m, vecs[i].q, prod, lat, width, bsy);
            total++;
            if (prod !== vecs[i].exp) $display("FAIL directed%0d product got %h want %h", i, prod, vecs[i].exp);
            else passed++;
            total++;
            if (lat != 10) $display("FAIL directed%0d latency got %0d want 10", i, lat);
            else passed++;
            total++;
            if (width != 1) $display("FAIL directed%0d done_width got %0d want 1", i, width);
            else passed++;
            total++;
            if (bsy !== 1'b1) $display("FAIL directed%0d busy_after_start got %b want 1", i, bsy);
            else passed++;
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0, first = -1;
        logic [15:0] prod = '0;
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b1; mc8 = 8'hFD; mq8 = 8'h05;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k == 2) begin start8 = 1'b1; sm8 = 1'b0; mc8 = 8'h11; mq8 = 8'h22; end
            if (k == 3) start8 = 1'b0;
            if (done8) begin
                ndone++;
                if (first < 0) begin first = k; prod = product8; end
            end
        end
        total++;
        if (first != 10 || prod !== 16'hFFF1) $display("FAIL ignore_start result got lat=%0d product=%h want 10/fff1", first, prod);
        else passed++;
        total++;
        if (ndone != 1) $display("FAIL ignore_start done_count got %0d want 1", ndone);
        else passed++;
        total++;
        if (product8 !== 16'hFFF1) $display("FAIL ignore_start product_hold got %h want fff1", product8);
        else passed++;
    endtask

    task automatic test_abort();
        int ndone = 0, lat, width;
        logic [15:0] prod, exp;
        logic bsy;
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; mc8 = 8'h37; mq8 = 8'h5A;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({busy8, done8, product8} !== 18'd0) $display("FAIL abort_reset got busy=%b done=%b product=%h want 0/0/0000", busy8, done8, product8);
        else passed++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        total++;
        if (ndone != 0 || busy8 !== 1'b0 || product8 !== 16'h0) $display("FAIL abort_quiet got done_count=%0d busy=%b product=%h want 0/0/0000", ndone, busy8, product8);
        else passed++;
        exp = 16'(ref_mul(1'b0, 8, 64'h37, 64'h5A));
        run8(1'b0, 8'h37, 8'h5A, prod, lat, width, bsy);
        total++;
        if (prod !== exp || lat != 10 || width != 1) $display("FAIL abort_restart got product=%h lat=%0d width=%0d want %h/10/1", prod, lat, width, exp);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int d1 = -1, d2 = -1;
        logic [15:0] p1 = '0, p2 = '0;
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; mc8 = 8'h0F; mq8 = 8'h0E;
        for (int k = 0; k <= 60 && d2 < 0; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                if (d1 < 0) begin d1 = k; p1 = product8; end
                else begin d2 = k; p2 = product8; start8 = 1'b0; end
            end
        end
        start8 = 1'b0;
        total++;
        if (d1 != 10 || d2 - d1 != 11) $display("FAIL back_to_back spacing got first=%0d second=%0d want 10/21", d1, d2);
        else passed++;
        total++;
        if (p1 !== 16'h00D2 || p2 !== 16'h00D2) $display("FAIL back_to_back product got %h,%h want 00d2", p1, p2);
        else passed++;
        for (int k = 0; k < 20 && busy8; k++) @(posedge clk);
        #1;
        total++;
        if (busy8 !== 1'b0) $display("FAIL back_to_back idle got busy=%b want 0", busy8);
        else passed++;
    endtask

    task automatic test_random16();
        logic s;
        logic [15:0] m, q;
        logic [31:0] prod, exp;
        int lat, width;
        for (int i = 0; i < 1000; i++) begin
            s = 1'($urandom_range(0, 1));
            m = 16'($urandom);
            q = 16'($urandom);
            if (i == 0) begin s = 1'b1; m = 16'h8000; q = 16'h8000; end
            if (i == 1) begin s = 1'b0; m = 16'hFFFF; q = 16'hFFFF; end
            if (i == 2) begin s = 1'b1; m = 16'h8000; q = 16'h7FFF; end
            exp = 32'(ref_mul(s, 16, longint'(m), longint'(q)));
            run16(s, m, q, prod, lat, width);
            total++;
            if (prod !== exp) $display("FAIL rand16[%0d] s=%b m=%h q=%h product got %h want %h", i, s, m, q, prod, exp);
            else passed++;
            total++;
            if (lat != 18 || width != 1) $display("FAIL rand16[%0d] timing got lat=%0d width=%0d want 18/1", i, lat, width);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        test_random16();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
